// File: rtl/rr_stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer: mode encodings and
// default channel geometry.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_NCH   = 4;

endpackage

// File: rtl/rr_stream_mux_if.sv
// Handshake bundle between N producers, the consumer and the multiplexer.
// The mux side uses the slave modport; the environment uses the master modport.
interface rr_stream_mux_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = DEFAULT_NCH
);
    localparam int SELW = $clog2(NCH);

    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH-1:0]         in_valid;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_ch;
    logic                   out_ready;

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from ptr, wrapping modulo NCH.
module rr_arbiter #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic found;
    int   idx;

    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (int'(ptr) + k) % NCH;
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = SELW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// Registered N:1 stream multiplexer with fixed-select and round-robin modes,
// a one-deep output register and full valid/ready back-pressure.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NCH   = DEFAULT_NCH,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    rr_stream_mux_if.slave   bus
);

    logic [SELW-1:0]  ptr;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;

    logic             load_ok;
    logic             sel_in_range;
    logic             fix_ok;
    logic             rr_mode;
    logic [NCH-1:0]   arb_gnt;
    logic [SELW-1:0]  arb_idx;
    logic             grant;
    logic [SELW-1:0]  gidx;
    logic [NCH-1:0]   in_ready_c;

    // Slot is free when empty or being drained this same cycle.
    assign load_ok      = !out_valid_q || bus.out_ready;
    assign rr_mode      = (bus.mode == MODE_RR);
    assign sel_in_range = (int'(bus.sel) < NCH);
    assign fix_ok       = load_ok && sel_in_range && bus.in_valid[bus.sel];

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .en      (load_ok && rr_mode && !reset),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        grant      = 1'b0;
        gidx       = '0;
        in_ready_c = '0;
        if (!reset) begin
            if (rr_mode) begin
                grant = |arb_gnt;
                gidx  = arb_idx;
            end else if (fix_ok) begin
                grant = 1'b1;
                gidx  = bus.sel;
            end
        end
        if (grant) in_ready_c[gidx] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data register is reset too, because out_data must read 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
        end else if (grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
            out_ch_q    <= gidx;
            if (rr_mode) ptr <= (int'(gidx) == NCH-1) ? '0 : gidx + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration and output-slot rules.
module tb_rr_stream_mux;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rr_stream_mux_if #(.WIDTH(32), .NCH(4)) bus ();
    rr_stream_mux_if #(.WIDTH(8),  .NCH(3)) b3 ();

    rr_stream_mux #(.WIDTH(32), .NCH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rr_stream_mux #(.WIDTH(8), .NCH(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    // Reference model state: one output slot plus the round-robin start point.
    bit          mv;
    logic [31:0] md;
    int          mch;
    int          mptr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mv = 1'b0; md = '0; mch = 0; mptr = 0;
    endtask

    function automatic int model_grant();
        if (mv && !bus.out_ready) return -1;
        if (bus.mode == MODE_FIXED) begin
            if (bus.in_valid[bus.sel]) return int'(bus.sel);
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            int c = (mptr + k) % 4;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a negedge with inputs driven; returns at the following negedge.
    task automatic tick();
        int         g;
        logic [3:0] er;
        #1;
        g  = model_grant();
        er = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("in_ready", {124'b0, bus.in_ready}, {124'b0, er});
        @(posedge clk);
        if (g >= 0) begin
            mv  = 1'b1;
            md  = bus.in_data[g*32 +: 32];
            mch = g;
            if (bus.mode == MODE_RR) mptr = (g + 1) % 4;
        end else if (mv && bus.out_ready) begin
            mv = 1'b0;
        end
        @(negedge clk);
        check("out_valid", {127'b0, bus.out_valid}, {127'b0, mv});
        if (mv) begin
            check("out_data", {96'b0, bus.out_data}, {96'b0, md});
            check("out_ch", {126'b0, bus.out_ch}, 128'(mch));
        end
    endtask

    task automatic tick3();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          rr_seq [6] = '{0, 1, 2, 3, 0, 1};
        int          sp_seq [3] = '{3, 1, 3};
        int          w3_seq [3] = '{1, 2, 0};
        logic [31:0] saved;

        reset = 1'b1;
        model_reset();
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        b3.mode = 1'b0; b3.sel = 2'd0; b3.in_valid = 3'b000;
        b3.in_data = 24'h332211; b3.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {124'b0, bus.in_ready}, 128'h0);
        check("rst_out_valid", {127'b0, bus.out_valid}, 128'h0);
        check("rst_out_data", {96'b0, bus.out_data}, 128'h0);
        check("rst_out_ch", {126'b0, bus.out_ch}, 128'h0);
        reset = 1'b0;

        // Fixed select of channel 2.
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        bus.in_data[64 +: 32] = 32'hDEADBEEF;
        #1 check("fix_ready", {124'b0, bus.in_ready}, 128'h4);
        tick();
        check("fix_data", {96'b0, bus.out_data}, 128'hDEADBEEF);
        check("fix_ch", {126'b0, bus.out_ch}, 128'd2);

        // Round-robin, all channels valid: no bubbles.
        foreach (rr_seq[i]) begin
            drive(1'b1, 2'd0, 4'hF, 1'b1);
            tick();
            check("rr_ch", {126'b0, bus.out_ch}, 128'(rr_seq[i]));
            check("rr_valid", {127'b0, bus.out_valid}, 128'h1);
        end

        // Round-robin with only channels 1 and 3 requesting, starting at ptr 2.
        foreach (sp_seq[i]) begin
            drive(1'b1, 2'd0, 4'b1010, 1'b1);
            tick();
            check("sparse_ch", {126'b0, bus.out_ch}, 128'(sp_seq[i]));
        end

        // Back-pressure holds the word and blocks every channel.
        saved = md;
        repeat (3) begin
            drive(1'b1, 2'd0, 4'hF, 1'b0);
            #1 check("bp_ready", {124'b0, bus.in_ready}, 128'h0);
            tick();
            check("bp_data", {96'b0, bus.out_data}, {96'b0, saved});
        end
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        #1 check("drain_ready", {124'b0, bus.in_ready}, 128'h1);
        tick();
        check("drain_ch", {126'b0, bus.out_ch}, 128'd0);
        check("drain_valid", {127'b0, bus.out_valid}, 128'h1);

        // Idle inputs: slot empties one cycle after the last drain.
        drive(1'b1, 2'd0, 4'h0, 1'b1);
        tick();
        check("idle_valid", {127'b0, bus.out_valid}, 128'h0);

        // Reset with a word held discards it immediately.
        drive(1'b1, 2'd0, 4'hF, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {127'b0, bus.out_valid}, 128'h0);
        check("mid_rst_data", {96'b0, bus.out_data}, 128'h0);
        check("mid_rst_ch", {126'b0, bus.out_ch}, 128'h0);
        check("mid_rst_ready", {124'b0, bus.in_ready}, 128'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        tick();
        check("post_rst_ch", {126'b0, bus.out_ch}, 128'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom_range(0, 9) < 7));
            tick();
        end

        // Three-channel instance: out-of-range select, then same-cycle mode switch and wrap.
        b3.mode = 1'b0; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
        #1 check("oor_ready", {125'b0, b3.in_ready}, 128'h0);
        tick3();
        check("oor_valid", {127'b0, b3.out_valid}, 128'h0);
        b3.mode = 1'b1;
        #1 check("switch_ready", {125'b0, b3.in_ready}, 128'h1);
        tick3();
        check("switch_valid", {127'b0, b3.out_valid}, 128'h1);
        check("switch_ch", {126'b0, b3.out_ch}, 128'd0);
        check("switch_data", {120'b0, b3.out_data}, 128'h11);
        foreach (w3_seq[i]) begin
            tick3();
            check("wrap3_ch", {126'b0, b3.out_ch}, 128'(w3_seq[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
